syscall_ctrl: RTL and testbench

- Hardware system-call unit for the pipelined MIPS CPU.
- When the control unit decodes SYSCALL, this block stalls the pipeline and reads $v0/$a0.
- It services print_int, print_string and exit by emitting records on an output stream. For print_string it borrows the data-memory read port.
- Sits beside the control unit and register file; the data-memory read port is muxed by dm_sel.

---
 rtl/syscall_pkg.sv | 26 ++
 rtl/syscall_ctrl_byte_sel.sv | 14 +
 rtl/syscall_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_syscall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared service codes, record types and FSM states for syscall_ctrl.
// Optional word buffer selected by SYSCALL_WORD_BUF_EN.
package syscall_pkg;

   localparam logic [31:0] SC_PRINT_INT = 32'd1;
   localparam logic [31:0] SC_PRINT_STR = 32'd4;
   localparam logic [31:0] SC_EXIT      = 32'd10;

   typedef enum logic [1:0] {
      OT_CHAR = 2'd0,
      OT_INT  = 2'd1,
      OT_END  = 2'd2
   } out_type_e;

   typedef enum logic [2:0] {
      IDLE,
      INT_OUT,
      RD_REQ,
      RD_WAIT,
      CHAR_OUT,
      END_OUT,
      DONE,
      HALT
   } state_e;

endpackage

// File: rtl/syscall_ctrl_byte_sel.sv
// Little-endian byte-lane extractor: lane 0 = [7:0], lane 3 = [31:24].
// Shared by the DM read path and the word-buffer path.
module sc_byte_sel (
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   output logic [7:0]  byte_o
);

   // pick one byte out of the word
   always_comb begin
      byte_o = word_i[{lane_i, 3'b000} +: 8];
   end

endmodule

// File: rtl/syscall_ctrl.sv
// SYSCALL service unit: print_int, print_string and exit over a record stream.
// Define SYSCALL_WORD_BUF_EN to serve chars of the same word from a buffer.
module syscall_ctrl
   import syscall_pkg::*;
#(
   parameter int MAX_STR_LEN = 256,
   parameter int DM_AW       = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             syscall_valid,
   input  logic [31:0]      v0,
   input  logic [31:0]      a0,
   output logic             stall,
   output logic             syscall_done,
   output logic             dm_sel,
   output logic [DM_AW-1:0] dm_addr,
   input  logic [31:0]      dm_rdata,
   output logic             out_valid,
   output logic [1:0]       out_type,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   output logic             halt,
   output logic             err_invalid,
   output logic             err_trunc
);

   localparam int CW = $clog2(MAX_STR_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STR_LEN);

   state_e          state_q, state_d;
   logic [31:0]     ptr_q, ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      char_q, char_d;
   logic            inv_q, inv_d;

   logic [31:0]     ptr_inc;
   logic [CW-1:0]   count_inc;
   logic            last;
   logic            bad_code;
   logic [31:0]     sel_word;
   logic [1:0]      sel_lane;
   logic [7:0]      sel_byte;

   assign ptr_inc   = ptr_q + 32'd1;
   assign count_inc = count_q + CW'(1);
   assign last      = (count_inc == CNT_MAX);
   assign bad_code  = (v0 != SC_PRINT_INT) && (v0 != SC_PRINT_STR) &&
                      (v0 != SC_EXIT);
   assign dm_addr   = dm_sel ? ptr_q[DM_AW+1:2] : '0;

`ifdef SYSCALL_WORD_BUF_EN
   logic [31:0] buf_q, buf_d;
   logic [29:0] tag_q, tag_d;
   logic        bvld_q, bvld_d;
   logic        hit;

   assign hit      = bvld_q && (tag_q == ptr_inc[31:2]);
   assign sel_word = (state_q == RD_WAIT) ? dm_rdata : buf_q;
   assign sel_lane = (state_q == RD_WAIT) ? ptr_q[1:0] : ptr_inc[1:0];

   // word buffer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         tag_q  <= '0;
         bvld_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         tag_q  <= tag_d;
         bvld_q <= bvld_d;
      end
   end

   // refill on every DM read, drop on a new syscall
   always_comb begin
      buf_d  = buf_q;
      tag_d  = tag_q;
      bvld_d = bvld_q;
      if (state_q == IDLE && syscall_valid) begin
         bvld_d = 1'b0;
      end else if (state_q == RD_WAIT) begin
         buf_d  = dm_rdata;
         tag_d  = ptr_q[31:2];
         bvld_d = 1'b1;
      end
   end
`else
   assign sel_word = dm_rdata;
   assign sel_lane = ptr_q[1:0];
`endif

   sc_byte_sel u_byte_sel (
      .word_i (sel_word),
      .lane_i (sel_lane),
      .byte_o (sel_byte)
   );

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         char_q  <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         char_q  <= char_d;
         inv_q   <= inv_d;
      end
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (syscall_valid) begin
            if (v0 == SC_PRINT_INT)      state_d = INT_OUT;
            else if (v0 == SC_PRINT_STR) state_d = RD_REQ;
            else if (v0 == SC_EXIT)      state_d = HALT;
            else                         state_d = DONE;
         end
         INT_OUT: if (out_ready) state_d = DONE;
         RD_REQ:  state_d = RD_WAIT;
         RD_WAIT: state_d = (sel_byte == 8'h00) ? END_OUT : CHAR_OUT;
         CHAR_OUT: if (out_ready) begin
            if (last) state_d = END_OUT;
`ifdef SYSCALL_WORD_BUF_EN
            else if (hit)
               state_d = (sel_byte == 8'h00) ? END_OUT : CHAR_OUT;
`endif
            else state_d = RD_REQ;
         end
         END_OUT: if (out_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // pointer, count, fetched char and invalid-code flag
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      char_d  = char_q;
      inv_d   = inv_q;
      unique case (state_q)
         IDLE: if (syscall_valid) begin
            ptr_d   = a0;
            count_d = '0;
            inv_d   = bad_code;
         end
         RD_WAIT: char_d = sel_byte;
         CHAR_OUT: if (out_ready) begin
            ptr_d   = ptr_inc;
            count_d = count_inc;
`ifdef SYSCALL_WORD_BUF_EN
            char_d  = sel_byte;
`endif
         end
         DONE:    inv_d = 1'b0;
         default: ;
      endcase
   end

   // Moore outputs, plus stall in IDLE and the trunc pulse on handshake
   always_comb begin
      stall        = 1'b1;
      syscall_done = 1'b0;
      dm_sel       = 1'b0;
      out_valid    = 1'b0;
      out_type     = OT_CHAR;
      out_data     = '0;
      halt         = 1'b0;
      err_invalid  = 1'b0;
      err_trunc    = 1'b0;
      unique case (state_q)
         IDLE: stall = syscall_valid;
         INT_OUT: begin
            out_valid = 1'b1;
            out_type  = OT_INT;
            out_data  = ptr_q;
         end
         RD_REQ, RD_WAIT: dm_sel = 1'b1;
         CHAR_OUT: begin
            out_valid = 1'b1;
            out_type  = OT_CHAR;
            out_data  = {24'h0, char_q};
            err_trunc = out_ready && last;
         end
         END_OUT: begin
            out_valid = 1'b1;
            out_type  = OT_END;
         end
         DONE: begin
            stall        = 1'b0;
            syscall_done = 1'b1;
            err_invalid  = inv_q;
         end
         HALT:    halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Randomised bench for syscall_ctrl against a string-walking reference model.
// Honours SYSCALL_WORD_BUF_EN for DM read-pattern and latency expectations.
module tb_syscall_ctrl;
   import syscall_pkg::*;

   localparam int MAXL  = 4;
   localparam int DM_AW = 30;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             syscall_valid;
   logic [31:0]      v0, a0;
   logic             stall, syscall_done, dm_sel;
   logic [DM_AW-1:0] dm_addr;
   logic [31:0]      dm_rdata;
   logic             out_valid;
   logic [1:0]       out_type;
   logic [31:0]      out_data;
   logic             out_ready;
   logic             halt, err_invalid, err_trunc;

   logic [31:0] mem [0:2047];

   logic [33:0] exp_rec[$], got_rec[$];
   logic [31:0] exp_rd[$], got_rd[$];
   int          e_trunc, e_inv;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) dm_rdata <= mem[dm_addr[10:0]];

   syscall_ctrl #(.MAX_STR_LEN(MAXL), .DM_AW(DM_AW)) dut (
      .clk(clk), .rst(rst), .syscall_valid(syscall_valid),
      .v0(v0), .a0(a0), .stall(stall), .syscall_done(syscall_done),
      .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
      .out_valid(out_valid), .out_type(out_type), .out_data(out_data),
      .out_ready(out_ready), .halt(halt), .err_invalid(err_invalid),
      .err_trunc(err_trunc)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[12:2]];
      return w[{a[1:0], 3'b000} +: 8];
   endfunction

   task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
      logic [31:0] w;
      w = mem[a[12:2]];
      w[{a[1:0], 3'b000} +: 8] = b;
      mem[a[12:2]] = w;
   endtask

   task automatic put_rand_str(input logic [31:0] a, input int len);
      for (int i = 0; i < len; i++)
         put_byte(a + i, 8'($urandom_range(255, 1)));
      put_byte(a + len, 8'h00);
   endtask

   // reference: walk bytes from the argument address
   task automatic model(input logic [31:0] code, input logic [31:0] arg);
      logic [31:0] p;
      logic [31:0] prevw;
      logic [7:0]  b;
      int          n;
      bit          first;
      exp_rec.delete();
      exp_rd.delete();
      e_trunc = 0;
      e_inv   = 0;
      if (code == 32'd1) begin
         exp_rec.push_back({2'd1, arg});
      end else if (code == 32'd4) begin
         p = arg;
         n = 0;
         first = 1;
         prevw = '0;
         while (1) begin
`ifdef SYSCALL_WORD_BUF_EN
            if (first || (p >> 2) != prevw) exp_rd.push_back(p >> 2);
`else
            exp_rd.push_back(p >> 2);
`endif
            first = 0;
            prevw = p >> 2;
            b = get_byte(p);
            if (b == 8'h00) break;
            exp_rec.push_back({2'd0, 24'h0, b});
            n++;
            p = p + 1;
            if (n == MAXL) begin
               e_trunc = 1;
               break;
            end
         end
         exp_rec.push_back({2'd2, 32'h0});
      end else if (code != 32'd10) begin
         e_inv = 1;
      end
   endtask

   // rmode: 0 always ready, 1 toggling, 2 random
   task automatic run_call(input logic [31:0] code, input logic [31:0] arg,
                           input int rmode, output int done_at);
      int          cyc, ntr, ninv, stall_bad, n;
      bit          hold, prev_sel;
      logic [1:0]  held_t;
      logic [31:0] held_d;
      model(code, arg);
      got_rec.delete();
      got_rd.delete();
      done_at = -1;
      cyc = 0; ntr = 0; ninv = 0; stall_bad = 0;
      hold = 0; prev_sel = 0;
      held_t = '0; held_d = '0;
      @(negedge clk);
      syscall_valid = 1'b1;
      v0 = code;
      a0 = arg;
      while (cyc < 1000) begin
         if (rmode == 0)      out_ready = 1'b1;
         else if (rmode == 1) out_ready = (cyc % 2) == 0;
         else                 out_ready = 1'($urandom % 2);
         #1;
         if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_type", 32'(out_type), 32'(held_t));
            chk("hold_data", out_data, held_d);
         end
         hold   = out_valid && !out_ready;
         held_t = out_type;
         held_d = out_data;
         if (out_valid && out_ready) got_rec.push_back({out_type, out_data});
         if (dm_sel && !prev_sel) got_rd.push_back(32'(dm_addr));
         prev_sel = dm_sel;
         ntr  += int'(err_trunc);
         ninv += int'(err_invalid);
         if (stall !== !syscall_done) stall_bad++;
         if (syscall_done) begin
            done_at = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      syscall_valid = 1'b0;
      chk("done_seen", 32'(done_at >= 0), 32'd1);
      chk("stall_pat", 32'(stall_bad), 32'd0);
      chk("trunc_cnt", 32'(ntr), 32'(e_trunc));
      chk("inv_cnt", 32'(ninv), 32'(e_inv));
      chk("rec_cnt", 32'(got_rec.size()), 32'(exp_rec.size()));
      n = (got_rec.size() < exp_rec.size()) ? got_rec.size() : exp_rec.size();
      for (int i = 0; i < n; i++) begin
         chk("rec_type", 32'(got_rec[i][33:32]), 32'(exp_rec[i][33:32]));
         chk("rec_data", got_rec[i][31:0], exp_rec[i][31:0]);
      end
      chk("rd_cnt", 32'(got_rd.size()), 32'(exp_rd.size()));
      n = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
      for (int i = 0; i < n; i++)
         chk("rd_addr", got_rd[i], exp_rd[i]);
   endtask

   initial begin
      int          d, nchar, hbad;
      bit          found;
      logic [31:0] code, addr;
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      syscall_valid = 1'b0;
      v0 = '0;
      a0 = '0;
      out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(syscall_done), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_dmsel", 32'(dm_sel), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_errs", 32'({err_invalid, err_trunc}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_call(32'd1, 32'hFFFF_FFF6, 0, d);
      chk("int_lat", 32'(d), 32'd2);

      mem[11'h400] = 32'h0A69_4800;
      mem[11'h401] = 32'h0000_0000;
      run_call(32'd4, 32'h0000_1001, 0, d);
`ifdef SYSCALL_WORD_BUF_EN
      chk("str_lat", 32'(d), 32'd9);
`else
      chk("str_lat", 32'(d), 32'd13);
`endif

      run_call(32'd4, 32'h0000_1004, 0, d);

      put_byte(32'h1100, 8'h48);
      put_byte(32'h1101, 8'h69);
      put_byte(32'h1102, 8'h00);
      run_call(32'd4, 32'h0000_1100, 1, d);

      put_rand_str(32'h1203, 10);
      run_call(32'd4, 32'h0000_1203, 0, d);

      run_call(32'd7, 32'h0, 0, d);
      chk("inv_lat", 32'(d), 32'd1);

      for (int k = 0; k < 40; k++) begin
         case ($urandom % 4)
            0: code = 32'd1;
            1: begin
               code = $urandom;
               while (code == 1 || code == 4 || code == 10) code = $urandom;
            end
            default: code = 32'd4;
         endcase
         if (code == 32'd4) begin
            addr = 32'($urandom_range(32'h1EF0, 32'h1000));
            put_rand_str(addr, int'($urandom_range(10, 0)));
         end else begin
            addr = $urandom;
         end
         run_call(code, addr, int'($urandom % 3), d);
      end

      @(negedge clk);
      syscall_valid = 1'b1;
      v0 = 32'd4;
      a0 = 32'h0000_1100;
      out_ready = 1'b1;
      found = 0;
      nchar = 0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (out_valid && out_type == 2'd0 && nchar == 1) begin
            found = 1;
            break;
         end
         if (out_valid && out_ready && out_type == 2'd0) nchar++;
         @(negedge clk);
      end
      chk("rst_found", 32'(found), 32'd1);
      syscall_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_dmsel", 32'(dm_sel), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_call(32'd1, 32'h1234_5678, 0, d);
      chk("post_rst_lat", 32'(d), 32'd2);

      @(negedge clk);
      syscall_valid = 1'b1;
      v0 = 32'd10;
      a0 = 32'h0;
      #1;
      chk("halt_c0", 32'(halt), 32'd0);
      hbad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         if (!halt || !stall || syscall_done || out_valid) hbad++;
      end
      chk("halt_hold", 32'(hbad), 32'd0);
      syscall_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
